// File: rtl/cr_kme_kop_kdf_stream_gather_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_kme_kop_kdf_stream_gather_if
// Brief    : Pipe-drain and block-output handshake bundle for the KDF gather.
// Revision : 1.0  initial release
// ============================================================================
interface cr_kme_kop_kdf_stream_gather_if #(
    parameter int BLOCK_BYTES = 64,
    parameter int AVAIL_W     = 6
);
    localparam int c_CNT_W = $clog2(BLOCK_BYTES) + 1;

    logic                     pipe_valid;
    logic [127:0]             pipe_data;
    logic [AVAIL_W-1:0]       pipe_avail;
    logic                     pipe_ack;
    logic [4:0]               pipe_ack_num_bytes;
    logic                     blk_valid;
    logic                     blk_ready;
    logic [BLOCK_BYTES*8-1:0] blk_data;
    logic [c_CNT_W-1:0]       blk_num_bytes;
    logic                     blk_last;

    // master: the gather engine; slave: pipe producer plus block consumer
    modport master (
        input  pipe_valid, pipe_data, pipe_avail, blk_ready,
        output pipe_ack, pipe_ack_num_bytes, blk_valid, blk_data, blk_num_bytes, blk_last
    );
    modport slave (
        output pipe_valid, pipe_data, pipe_avail, blk_ready,
        input  pipe_ack, pipe_ack_num_bytes, blk_valid, blk_data, blk_num_bytes, blk_last
    );
endinterface
`default_nettype wire

// File: rtl/cr_kme_kop_kdf_stream_gather.sv
`default_nettype none
// ============================================================================
// Module   : cr_kme_kop_kdf_stream_gather
// Brief    : Drains a left-justified byte pipe and packs a requested number of
//            bytes MSB-first into fixed-size blocks for the KDF hash engine.
// Revision : 1.0  initial release
// ============================================================================
module cr_kme_kop_kdf_stream_gather #(
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_W       = 16,
    parameter int AVAIL_W     = 6
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 start,
    input  wire [LEN_W-1:0]     start_len,
    output logic                busy,
    cr_kme_kop_kdf_stream_gather_if.master bus
);
    localparam int                 c_CNT_W = $clog2(BLOCK_BYTES) + 1;
    localparam int                 c_BW    = BLOCK_BYTES * 8;
    localparam logic [c_CNT_W-1:0] c_BB    = c_CNT_W'(BLOCK_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [LEN_W-1:0]   r_remaining, w_remaining_nxt;
    logic [c_CNT_W-1:0] r_fill,      w_fill_nxt;
    logic [c_BW-1:0]    r_buf,       w_buf_nxt;

    logic [c_CNT_W-1:0] w_space;
    logic [c_CNT_W-1:0] w_fill_upd;
    logic [LEN_W-1:0]   w_rem_upd;
    logic [4:0]         w_n_avail;
    logic [4:0]         w_n_rem;
    logic [4:0]         w_n;
    logic               w_ack;
    logic [127:0]       w_keep;
    logic [c_BW-1:0]    w_ins;

    // n = min(16, avail, remaining, space); remaining and space are never 0 in FILL
    always_comb begin : p_count
        w_space    = c_BB - r_fill;
        w_n_avail  = (bus.pipe_avail > AVAIL_W'(16)) ? 5'd16 : bus.pipe_avail[4:0];
        w_n_rem    = (r_remaining < LEN_W'(w_n_avail)) ? r_remaining[4:0] : w_n_avail;
        w_n        = (w_space < c_CNT_W'(w_n_rem)) ? w_space[4:0] : w_n_rem;
        w_ack      = (r_state == S_FILL) && bus.pipe_valid && (w_n != 5'd0);
        w_fill_upd = r_fill + c_CNT_W'(w_n);
        w_rem_upd  = r_remaining - LEN_W'(w_n);
    end

    always_comb begin : p_keep
        w_keep = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < w_n) begin
                w_keep[127-8*i -: 8] = bus.pipe_data[127-8*i -: 8];
            end
        end
    end

    // Bytes above fill are always zero, so placement is an OR of the shifted window
    generate
        if (c_BW == 128) begin : g_ins_narrow
            assign w_ins = w_keep >> {r_fill, 3'b000};
        end else begin : g_ins_wide
            assign w_ins = {w_keep, {(c_BW-128){1'b0}}} >> {r_fill, 3'b000};
        end
    endgenerate

    always_comb begin : p_next
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_fill_nxt      = r_fill;
        w_buf_nxt       = r_buf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_remaining_nxt = start_len;
                    w_fill_nxt      = '0;
                    w_buf_nxt       = '0;
                    // zero length still yields one empty last block
                    w_state_nxt     = (start_len != '0) ? S_FILL : S_EMIT;
                end
            end
            S_FILL: begin
                if (w_ack) begin
                    w_buf_nxt       = r_buf | w_ins;
                    w_fill_nxt      = w_fill_upd;
                    w_remaining_nxt = w_rem_upd;
                    if ((w_fill_upd == c_BB) || (w_rem_upd == '0)) begin
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (bus.blk_ready) begin
                    if (r_remaining == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FILL;
                        w_fill_nxt  = '0;
                        w_buf_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin : p_out
        busy                   = (r_state != S_IDLE);
        bus.pipe_ack           = w_ack;
        bus.pipe_ack_num_bytes = w_ack ? w_n : 5'd0;
        bus.blk_valid          = (r_state == S_EMIT);
        bus.blk_data           = (r_state == S_EMIT) ? r_buf : '0;
        bus.blk_num_bytes      = (r_state == S_EMIT) ? r_fill : '0;
        bus.blk_last           = (r_state == S_EMIT) && (r_remaining == '0);
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_fill      <= '0;
            r_buf       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_fill      <= w_fill_nxt;
            r_buf       <= w_buf_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cr_kme_kop_kdf_stream_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_kme_kop_kdf_stream_gather
// Brief    : Self-checking bench: directed table, corner sequences, random runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_cr_kme_kop_kdf_stream_gather;
    localparam int BB      = 64;
    localparam int BW      = BB * 8;
    localparam int LEN_W   = 16;
    localparam int AVAIL_W = 6;

    typedef logic [7:0] u8_t;
    typedef struct {
        int len; int cap; int extra; int stall;
        int exp_nblk; int exp_last_nb; int exp_nacks;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] start_len;
    logic             busy;

    cr_kme_kop_kdf_stream_gather_if #(.BLOCK_BYTES(BB), .AVAIL_W(AVAIL_W)) bus ();

    cr_kme_kop_kdf_stream_gather #(
        .BLOCK_BYTES(BB), .LEN_W(LEN_W), .AVAIL_W(AVAIL_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_len (start_len),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte stream queue plus gather progress counters
    u8_t pq[$];
    u8_t m_stream[$];
    int  m_len, m_taken, m_blk_start, m_nblk, m_nacks, m_last_nb, stall_left;
    bit  m_wait, m_done;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_data(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // cap>0: avail limited to cap; cap==0: random avail each cycle
    task automatic drive_pipe(int cap);
        int a;
        logic [127:0] d;
        a = pq.size();
        if (cap > 0) begin
            if (a > cap) a = cap;
        end else begin
            if (a > 20) a = 20;
            a = int'($urandom_range(a, 0));
        end
        if (a > 63) a = 63;
        for (int i = 0; i < 16; i++) d[127-8*i -: 8] = (i < a) ? pq[i] : 8'($urandom);
        bus.pipe_data  = d;
        bus.pipe_avail = 6'(a);
        bus.pipe_valid = (a != 0);
    endtask

    task automatic check_cycle();
        int av, en, nb;
        bit ea, last;
        logic [BW-1:0] ed;
        if (m_done) return;
        chk("busy", int'(busy), 1);
        if (!m_wait) begin
            av = int'(bus.pipe_avail);
            en = (av > 16) ? 16 : av;
            if (en > m_len - m_taken) en = m_len - m_taken;
            if (en > BB - (m_taken - m_blk_start)) en = BB - (m_taken - m_blk_start);
            ea = bus.pipe_valid && (en != 0);
            chk("pipe_ack", int'(bus.pipe_ack), int'(ea));
            chk("ack_num", int'(bus.pipe_ack_num_bytes), ea ? en : 0);
            chk("blk_valid_fill", int'(bus.blk_valid), 0);
            if (ea) begin
                for (int k = 0; k < en; k++) m_stream.push_back(pq.pop_front());
                m_taken += en;
                m_nacks++;
                if ((m_taken - m_blk_start == BB) || (m_taken == m_len)) m_wait = 1'b1;
            end
        end else begin
            nb   = m_taken - m_blk_start;
            last = (m_taken == m_len);
            ed   = '0;
            for (int k = 0; k < nb; k++) ed[BW-1-8*k -: 8] = m_stream[m_blk_start + k];
            chk("pipe_ack_emit", int'(bus.pipe_ack), 0);
            chk("blk_valid", int'(bus.blk_valid), 1);
            chk("blk_num_bytes", int'(bus.blk_num_bytes), nb);
            chk("blk_last", int'(bus.blk_last), int'(last));
            chk_data("blk_data", bus.blk_data, ed);
            if (bus.blk_ready) begin
                m_nblk++;
                if (last) begin
                    m_done    = 1'b1;
                    m_last_nb = nb;
                end else begin
                    m_blk_start = m_taken;
                    m_wait      = 1'b0;
                end
            end
        end
    endtask

    task automatic start_gather(int len, int cap, int extra, bit seq);
        pq.delete();
        m_stream.delete();
        for (int i = 0; i < len + extra; i++) pq.push_back(seq ? 8'(i) : 8'($urandom));
        @(posedge clk); #1;
        start = 1'b1; start_len = 16'(len); bus.blk_ready = 1'b0;
        drive_pipe(cap);
        @(negedge clk);
        chk("busy_at_start", int'(busy), 0);
        chk("ack_at_start", int'(bus.pipe_ack), 0);
        m_len = len; m_taken = 0; m_blk_start = 0; m_nblk = 0; m_nacks = 0; m_last_nb = -1;
        m_wait = (len == 0); m_done = 1'b0;
    endtask

    task automatic run_gather(int len, int cap, int extra, int stall, bit rnd_ready, int inj, bit seq);
        int cyc;
        start_gather(len, cap, extra, seq);
        stall_left = stall;
        cyc = 0;
        while (!m_done && cyc < 3000) begin
            @(posedge clk); #1;
            start = (cyc == inj);
            if (cyc == inj) start_len = 16'd5;
            drive_pipe(cap);
            if (m_wait && stall_left > 0) begin
                bus.blk_ready = 1'b0;
                stall_left--;
            end else begin
                bus.blk_ready = rnd_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            @(negedge clk);
            check_cycle();
            cyc++;
        end
        if (!m_done) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: gather of %0d bytes not complete after %0d cycles", len, cyc);
        end
        @(posedge clk); #1;
        start = 1'b0; bus.blk_ready = 1'b0;
        drive_pipe(cap);
        @(negedge clk);
        chk("busy_after", int'(busy), 0);
        chk("blk_valid_after", int'(bus.blk_valid), 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{20,  63,  0, 0, 1, 20, 2};
        vecs[1] = '{64,  63, 16, 0, 1, 64, 4};
        vecs[2] = '{100, 63, 16, 5, 2, 36, 7};
        vecs[3] = '{70,  12, 16, 0, 2,  6, 7};
        vecs[4] = '{0,   63, 16, 0, 1,  0, 0};
        vecs[5] = '{128, 63, 16, 0, 2, 64, 8};
        vecs[6] = '{17,   5, 16, 0, 1, 17, 4};
        vecs[7] = '{1,   63, 16, 0, 1,  1, 1};

        rst = 1'b1; start = 1'b0; start_len = '0;
        bus.pipe_valid = 1'b0; bus.pipe_data = '0; bus.pipe_avail = '0; bus.blk_ready = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(bus.pipe_ack), 0);
        chk("rst_ack_num", int'(bus.pipe_ack_num_bytes), 0);
        chk("rst_blk_valid", int'(bus.blk_valid), 0);
        chk("rst_blk_num", int'(bus.blk_num_bytes), 0);
        chk("rst_blk_last", int'(bus.blk_last), 0);
        chk_data("rst_blk_data", bus.blk_data, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_gather(vecs[v].len, vecs[v].cap, vecs[v].extra, vecs[v].stall, 1'b0, -1, 1'b1);
            chk("tbl_nblk", m_nblk, vecs[v].exp_nblk);
            chk("tbl_last_nb", m_last_nb, vecs[v].exp_last_nb);
            chk("tbl_nacks", m_nacks, vecs[v].exp_nacks);
        end

        // start pulsed mid-gather must not disturb the running length
        run_gather(30, 4, 16, 0, 1'b0, 3, 1'b1);
        chk("ign_start_nblk", m_nblk, 1);
        chk("ign_start_last_nb", m_last_nb, 30);

        // reset during FILL after 8 bytes, then a clean gather
        start_gather(40, 4, 16, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0; bus.blk_ready = 1'b0;
            drive_pipe(4);
            @(negedge clk);
            check_cycle();
        end
        chk("pre_rst_taken", m_taken, 8);
        @(posedge clk); #1;
        drive_pipe(4);
        #2;
        chk("pre_rst_ack", int'(bus.pipe_ack), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", int'(bus.pipe_ack), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ack_num", int'(bus.pipe_ack_num_bytes), 0);
        @(posedge clk); #1 rst = 1'b0;
        run_gather(20, 63, 0, 0, 1'b0, -1, 1'b0);
        chk("post_rst_nblk", m_nblk, 1);
        chk("post_rst_last_nb", m_last_nb, 20);

        // random lengths, avail patterns and backpressure
        for (int r = 0; r < 25; r++) begin
            int len;
            len = int'($urandom_range(300, 0));
            run_gather(len, int'($urandom_range(16, 0)), int'($urandom_range(20, 0)), 0, 1'b1, -1, 1'b0);
            chk("rnd_nblk", m_nblk, (len == 0) ? 1 : (len + BB - 1) / BB);
            chk("rnd_last_nb", m_last_nb, (len == 0) ? 0 : ((len - 1) % BB) + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
